sysid_check_master: RTL and testbench
=====================================

Name: sysid_check_master

Overview:
- Avalon-MM read initiator that fetches the two 32-bit words of the system-ID slave and checks them against build-time expected values: word 0 is the ID, word 1 is the timestamp.
- Sits on the system interconnect as a master; its outputs feed the boot/status logic (LED, reset hold-off, CPU status register).
- Runs once after reset (optional) and again on every start pulse.

Parameters:
- ADDR_W, 32, width of the byte address output.
- BASE_ADDR, 32'h0000_0000, byte address of the ID word; the timestamp word is at BASE_ADDR+4.
- EXPECTED_ID, 32'd538117937, value word 0 must return.
- EXPECTED_TS, 32'd1381778683, value word 1 must return.
- TIMEOUT_CYCLES, 1024, maximum cycles per transfer (request through data), range 2..65535.
- AUTO_START, 1, when 1 a check launches automatically on the first clock after reset release.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that launches a check; ignored while busy=1
- avm_address  out  ADDR_W  byte address
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check finishes
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TS
- timeout  out  1  last check aborted on timeout
- id_value  out  32  last captured word 0
- ts_value  out  32  last captured word 1

Behaviour:
- Reset values (asynchronous): all outputs 0, avm_address = BASE_ADDR, state IDLE, timeout counter 0.
- States: IDLE -> RD_ID -> WT_ID -> RD_TS -> WT_TS -> FIN -> IDLE.
- Launch:
  - IDLE moves to RD_ID on a start pulse, or on the first cycle after reset when AUTO_START=1 (one-shot flag).
  - On entering RD_ID: clear id_ok, ts_ok and timeout; set busy=1.
  - id_value and ts_value keep their old values until overwritten.
- RD_ID:
  - Drive avm_read=1 and avm_address=BASE_ADDR.
  - Hold both stable while avm_waitrequest=1.
  - The request is accepted on the first cycle with avm_waitrequest=0; avm_read drops in the next cycle and the state moves to WT_ID.
- WT_ID:
  - On avm_readdatavalid=1: id_value <= avm_readdata; id_ok <= (avm_readdata == EXPECTED_ID); go to RD_TS.
  - readdatavalid arriving in the same cycle as acceptance (zero-latency slave) is also captured; in that case skip WT_ID and go directly to RD_TS.
- RD_TS / WT_TS:
  - Same protocol with address BASE_ADDR+4.
  - Capture into ts_value and ts_ok, then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Exactly one outstanding read at a time. readdatavalid in any state other than WT_ID, WT_TS, or the accept cycle is ignored.
- Timeout:
  - A 16-bit counter is cleared on entering RD_ID and RD_TS and increments each cycle in RD_* and WT_*.
  - If it reaches TIMEOUT_CYCLES-1 without data captured: deassert avm_read, set timeout=1, leave the not-yet-checked ok flags at 0, and go to FIN (done pulses).
  - Data arriving in the same cycle as expiry wins: data is captured and there is no timeout.
- start while busy=1 is dropped, not queued. start in the FIN cycle is also dropped.
- Reset asserted mid-transfer: immediate return to reset values; avm_read deasserts asynchronously.
- No combinational path from any avm_* input to avm_read or avm_address; all outputs are registered.

Test Plan:
- AUTO_START=1, zero-wait slave returning 538117937 then 1381778683 -> exactly two reads at addresses 0x0 and 0x4; done pulses once; id_ok=1, ts_ok=1, timeout=0.
- Slave returns 538117937 and then 0x12345678 -> id_ok=1, ts_ok=0, ts_value=0x12345678, done pulses once.
- waitrequest held for 5 cycles and readdatavalid 3 cycles after acceptance on each word -> avm_address and avm_read stable during the stall, correct capture, busy high throughout, done pulse.
- readdatavalid never asserted, TIMEOUT_CYCLES=16 -> avm_read low; timeout=1, id_ok=0, ts_ok=0, done exactly 16 cycles after the first request; a following start runs a clean check.
- start pulsed while busy -> ignored: still exactly two reads per check, a single done.
- reset_n asserted during WT_TS -> all outputs 0 immediately; with AUTO_START=1 a new check restarts at address 0x0 after release.

Source files
------------

// File: rtl/sysid_check_master.sv
// Avalon-MM read initiator: fetches the system-ID and timestamp words and
// compares them against build-time expected values, with a per-transfer timeout.
module sysid_check_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = 32'd538117937,
  parameter logic [31:0] EXPECTED_TS    = 32'd1381778683,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam int unsigned       CNT_W    = 16;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ID_ADDR  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TS_ADDR  = ADDR_W'(BASE_ADDR + 32'd4);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                auto_q, auto_d;
  logic                read_d, busy_d, done_d, id_ok_d, ts_ok_d, timeout_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         id_value_d, ts_value_d;

  logic in_rd_c, in_xfer_c, id_phase_c, accept_c, capture_c, expire_c;

  assign in_rd_c    = (state_q == RD_ID) || (state_q == RD_TS);
  assign in_xfer_c  = in_rd_c || (state_q == WT_ID) || (state_q == WT_TS);
  assign id_phase_c = (state_q == RD_ID) || (state_q == WT_ID);
  assign accept_c   = in_rd_c && !avm_waitrequest;
  // Data is accepted while waiting, or in the accept cycle of a zero-latency slave.
  assign capture_c  = avm_readdatavalid &&
                      (accept_c || (state_q == WT_ID) || (state_q == WT_TS));
  // Data arriving on the expiry cycle wins over the timeout.
  assign expire_c   = in_xfer_c && (cnt_q == CNT_LAST) && !capture_c;

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      auto_q      <= AUTO_START;
      avm_read    <= 1'b0;
      avm_address <= ID_ADDR;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      auto_q      <= auto_d;
      avm_read    <= read_d;
      avm_address <= addr_d;
      busy        <= busy_d;
      done        <= done_d;
      id_ok       <= id_ok_d;
      ts_ok       <= ts_ok_d;
      timeout     <= timeout_d;
      id_value    <= id_value_d;
      ts_value    <= ts_value_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start || auto_q) state_d = RD_ID;
      RD_ID: begin
        if (capture_c)     state_d = RD_TS;
        else if (expire_c) state_d = FIN;
        else if (accept_c) state_d = WT_ID;
      end
      WT_ID: begin
        if (capture_c)     state_d = RD_TS;
        else if (expire_c) state_d = FIN;
      end
      RD_TS: begin
        if (capture_c || expire_c) state_d = FIN;
        else if (accept_c)         state_d = WT_TS;
      end
      WT_TS: if (capture_c || expire_c) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    cnt_d      = cnt_q;
    auto_d     = auto_q;
    read_d     = avm_read;
    addr_d     = avm_address;
    busy_d     = busy;
    done_d     = 1'b0;
    id_ok_d    = id_ok;
    ts_ok_d    = ts_ok;
    timeout_d  = timeout;
    id_value_d = id_value;
    ts_value_d = ts_value;

    if (in_xfer_c) cnt_d = cnt_q + CNT_W'(1);
    if (accept_c)  read_d = 1'b0;

    if (capture_c && id_phase_c) begin
      id_value_d = avm_readdata;
      id_ok_d    = (avm_readdata == EXPECTED_ID);
    end
    if (capture_c && !id_phase_c) begin
      ts_value_d = avm_readdata;
      ts_ok_d    = (avm_readdata == EXPECTED_TS);
    end
    if (expire_c) begin
      read_d    = 1'b0;
      timeout_d = 1'b1;
    end

    if ((state_q == IDLE) && (state_d == RD_ID)) begin
      read_d    = 1'b1;
      addr_d    = ID_ADDR;
      busy_d    = 1'b1;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b0;
      cnt_d     = '0;
      auto_d    = 1'b0;
    end
    if ((state_q != RD_TS) && (state_d == RD_TS)) begin
      read_d = 1'b1;
      addr_d = TS_ADDR;
      cnt_d  = '0;
    end
    if ((state_q != FIN) && (state_d == FIN)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: behavioural Avalon slave with configurable
// stall/latency/drop, address and result scoreboards, and a vector table.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'd538117937;
  localparam logic [31:0] EXP_TS = 32'd1381778683;
  localparam logic [31:0] TS_A   = 32'h0000_0004;
  localparam int          TMO    = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  sysid_check_master #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] id_data;
    logic [31:0] ts_data;
    int          wait_cyc;
    int          lat;
    bit          drop_id;
    bit          drop_ts;
    bit          poke;
    bit          id_cap;
    bit          ts_cap;
    bit          e_id_ok;
    bit          e_ts_ok;
    bit          e_to;
  } vec_t;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
  } res_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int reads = 0;
  int dones = 0;
  int last_req_cyc = 0;
  int done_cyc = 0;

  logic [31:0] exp_addr_q[$];
  res_t        exp_res_q[$];
  logic [31:0] prev_id = '0;
  logic [31:0] prev_ts = '0;

  // Slave configuration and state
  logic [31:0] cfg_id, cfg_ts;
  int          cfg_wait = 0, cfg_lat = 1;
  bit          cfg_drop_id = 0, cfg_drop_ts = 0;
  int          stall = 0, lat_left = 0;
  bit          lat_pend = 0, pend_drop = 0;
  logic [31:0] pend_data = '0, cur_addr = '0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clock) cyc++;

  // Avalon slave model, driven on the falling edge
  always @(negedge clock) begin
    if (!reset_n) begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      lat_pend          = 1'b0;
      stall             = 0;
    end else begin
      avm_readdatavalid = 1'b0;
      if (lat_pend) begin
        lat_left--;
        if (lat_left == 0) begin
          lat_pend = 1'b0;
          if (!pend_drop) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_data;
          end
        end
      end
      if (avm_read) begin
        if (!avm_waitrequest) begin
          reads++;
          last_req_cyc = cyc;
          cur_addr     = avm_address;
          stall        = 0;
          if (exp_addr_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_read: got read at 0x%08h expected none", avm_address);
          end else begin
            chk("read_addr", avm_address, exp_addr_q.pop_front());
          end
        end else begin
          chk("addr_stable", avm_address, cur_addr);
        end
        chk("busy_during_read", 32'(busy), 32'd1);
        if (stall < cfg_wait) begin
          avm_waitrequest = 1'b1;
          stall++;
        end else begin
          avm_waitrequest = 1'b0;
          pend_data = (cur_addr == TS_A) ? cfg_ts : cfg_id;
          pend_drop = (cur_addr == TS_A) ? cfg_drop_ts : cfg_drop_id;
          if (cfg_lat == 0) begin
            if (!pend_drop) begin
              avm_readdatavalid = 1'b1;
              avm_readdata      = pend_data;
            end
          end else begin
            lat_pend = 1'b1;
            lat_left = cfg_lat;
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  // Result monitor
  always @(negedge clock) begin
    if (reset_n && done) begin
      res_t e;
      dones++;
      done_cyc = cyc;
      if (exp_res_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = exp_res_q.pop_front();
        chk("id_ok", 32'(id_ok), 32'(e.id_ok));
        chk("ts_ok", 32'(ts_ok), 32'(e.ts_ok));
        chk("timeout", 32'(timeout), 32'(e.to));
        chk("id_value", id_value, e.idv);
        chk("ts_value", ts_value, e.tsv);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_addr"}, avm_address, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_id_ok"}, 32'(id_ok), 32'd0);
    chk({tag, "_ts_ok"}, 32'(ts_ok), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_id_value"}, id_value, 32'd0);
    chk({tag, "_ts_value"}, ts_value, 32'd0);
  endtask

  // mode 0: launch by reset release, 1: start pulse, 2: start pulse plus start during done
  task automatic run_vec(input vec_t v, input int mode);
    res_t r;
    int   n;
    cfg_id = v.id_data; cfg_ts = v.ts_data; cfg_wait = v.wait_cyc; cfg_lat = v.lat;
    cfg_drop_id = v.drop_id; cfg_drop_ts = v.drop_ts;
    exp_addr_q.push_back(32'h0);
    if (v.id_cap) exp_addr_q.push_back(TS_A);
    if (v.id_cap) prev_id = v.id_data;
    if (v.ts_cap) prev_ts = v.ts_data;
    r.id_ok = v.e_id_ok; r.ts_ok = v.e_ts_ok; r.to = v.e_to;
    r.idv = prev_id; r.tsv = prev_ts;
    exp_res_q.push_back(r);
    reads = 0; dones = 0;
    @(negedge clock);
    if (mode == 0) reset_n = 1'b1;
    else start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (v.poke) begin
      repeat (3) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    n = 0;
    if (mode == 2) begin
      while (!done && n < 200) begin @(negedge clock); n++; end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end else begin
      while (dones == 0 && n < 200) begin @(negedge clock); n++; end
    end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: got no done within 200 cycles expected a done pulse");
    end
    repeat (20) @(negedge clock);
    chk("read_count", 32'(reads), v.id_cap ? 32'd2 : 32'd1);
    chk("done_count", 32'(dones), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    if (v.e_to) chk("timeout_latency", 32'(done_cyc - last_req_cyc), 32'(TMO));
  endtask

  vec_t tbl[12];

  initial begin
    int n;
    //          id      ts            wait lat dId dTs poke idC tsC idOk tsOk to
    tbl[0]  = '{EXP_ID, EXP_TS,        0,  1,  0,  0,  0,   1,  1,  1,   1,   0};
    tbl[1]  = '{EXP_ID, 32'h12345678,  0,  1,  0,  0,  0,   1,  1,  1,   0,   0};
    tbl[2]  = '{EXP_ID, EXP_TS,        5,  3,  0,  0,  1,   1,  1,  1,   1,   0};
    tbl[3]  = '{EXP_ID, EXP_TS,        0,  0,  0,  0,  0,   1,  1,  1,   1,   0};
    tbl[4]  = '{EXP_ID, EXP_TS,        3,  0,  0,  0,  0,   1,  1,  1,   1,   0};
    tbl[5]  = '{EXP_ID, EXP_TS,        0,  1,  1,  1,  0,   0,  0,  0,   0,   1};
    tbl[6]  = '{EXP_ID, EXP_TS,        0,  1,  0,  0,  0,   1,  1,  1,   1,   0};
    tbl[7]  = '{EXP_ID, 32'hCAFEF00D,  0,  1,  0,  1,  0,   1,  0,  1,   0,   1};
    tbl[8]  = '{EXP_ID, EXP_TS,        0, 15,  0,  0,  0,   1,  1,  1,   1,   0};
    tbl[9]  = '{32'h0BADBEEF, EXP_TS,  0, 16,  0,  0,  0,   0,  0,  0,   0,   1};
    tbl[10] = '{32'hDEADBEEF, EXP_TS,  0,  2,  0,  0,  0,   1,  1,  0,   1,   0};
    tbl[11] = '{EXP_ID, 32'h00000001, 14,  1,  0,  0,  0,   1,  1,  1,   0,   0};

    repeat (3) @(negedge clock);
    check_reset_outputs("rst");

    run_vec(tbl[0], 0);
    for (int i = 1; i < 12; i++) run_vec(tbl[i], 1);

    // start arriving in the done cycle must be dropped
    run_vec(tbl[0], 2);

    // reset during the timestamp wait, then auto-start again from address 0
    cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_wait = 0; cfg_lat = 10;
    cfg_drop_id = 0; cfg_drop_ts = 0;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(TS_A);
    reads = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (reads < 2 && n < 100) begin @(negedge clock); n++; end
    chk("midreset_reads", 32'(reads), 32'd2);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_addr_q.delete();
    exp_res_q.delete();
    prev_id = '0;
    prev_ts = '0;
    repeat (3) @(negedge clock);
    run_vec(tbl[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
